// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: operation codes,
// FSM state encoding and small op-classification helpers.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Multiply family (signed or unsigned)
    function automatic logic is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    // Divide family (signed or unsigned)
    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Ops that interpret operands as two's complement
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the pipeline (master) and the HI/LO unit (slave).
//
// Handshake: there is no ready signal. The master raises start for one
// cycle with op/A/B valid; the unit samples it on the rising edge. A start
// that arrives while busy=1, or that carries NONE or an undefined code, is
// dropped silently. Arithmetic ops raise busy from the cycle after the
// accepting edge and finish with a one-cycle done pulse, at which point HI/LO
// already hold the result. MTHI/MTLO complete on the accepting edge with no
// busy or done activity. dbg_state mirrors the internal FSM state.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    import muldiv_unit_pkg::*;

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    state_e           dbg_state;

    modport master (
        output start, op, A, B,
        input  busy, done, HI, LO, dbg_state
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, HI, LO, dbg_state
    );

endinterface

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit. Operands are latched on acceptance, the result
// is formed combinationally from the latched copies, and HI/LO are committed
// on the edge that ends the final busy cycle. A down-counter sets latency.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic               w_latch;

    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;

    // Multiply datapath: extend both operands to the full product width so a
    // single truncated multiply yields the exact signed or unsigned product.
    logic [2*WIDTH-1:0] w_a_sx;
    logic [2*WIDTH-1:0] w_b_sx;
    logic [2*WIDTH-1:0] w_a_zx;
    logic [2*WIDTH-1:0] w_b_zx;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [2*WIDTH-1:0] w_prod;

    assign w_a_sx   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_b_sx   = {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_a_zx   = {{WIDTH{1'b0}}, r_a};
    assign w_b_zx   = {{WIDTH{1'b0}}, r_b};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = w_a_zx * w_b_zx;
    assign w_prod   = is_signed_op(r_op) ? w_prod_s : w_prod_u;

    // Divide datapath: divide magnitudes unsigned, then restore signs so the
    // quotient truncates toward zero and the remainder follows the dividend.
    // The most-negative / -1 case falls out naturally: its magnitude wraps
    // back to the most-negative pattern and the remainder is zero.
    logic             w_sgn;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_num;
    logic [WIDTH-1:0] w_den;
    logic [WIDTH-1:0] w_den_safe;
    logic [WIDTH-1:0] w_uq;
    logic [WIDTH-1:0] w_ur;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;
    logic             w_div_zero;

    assign w_sgn      = is_signed_op(r_op);
    assign w_a_neg    = w_sgn & r_a[WIDTH-1];
    assign w_b_neg    = w_sgn & r_b[WIDTH-1];
    assign w_num      = w_a_neg ? ({WIDTH{1'b0}} - r_a) : r_a;
    assign w_den      = w_b_neg ? ({WIDTH{1'b0}} - r_b) : r_b;
    assign w_div_zero = (r_b == {WIDTH{1'b0}});
    // A zero divisor never commits; substituting 1 keeps the divider defined.
    assign w_den_safe = w_div_zero ? ONE_W : w_den;
    assign w_uq       = w_num / w_den_safe;
    assign w_ur       = w_num % w_den_safe;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? ({WIDTH{1'b0}} - w_uq) : w_uq;
    assign w_rem      = w_a_neg ? ({WIDTH{1'b0}} - w_ur) : w_ur;

    // Next-state, counter and HI/LO update decisions for the IDLE/RUN FSM
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_mul(bus.op)) begin
                        w_latch     = 1'b1;
                        w_cnt_nxt   = MUL_LOAD;
                        w_state_nxt = ST_RUN;
                    end else if (is_div(bus.op)) begin
                        w_latch     = 1'b1;
                        w_cnt_nxt   = DIV_LOAD;
                        w_state_nxt = ST_RUN;
                    end else if (bus.op == OP_MTHI) begin
                        w_hi_nxt = bus.A;
                    end else if (bus.op == OP_MTLO) begin
                        w_lo_nxt = bus.A;
                    end
                end
            end
            ST_RUN: begin
                // Start requests are ignored for the whole RUN period
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    if (is_mul(r_op)) begin
                        w_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
                        w_lo_nxt = w_prod[WIDTH-1:0];
                    end else if (!w_div_zero) begin
                        w_hi_nxt = w_rem;
                        w_lo_nxt = w_quot;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, latency counter, done pulse and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Operand capture on acceptance; later changes on A/B are not seen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op <= OP_NONE;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_latch) begin
            r_op <= bus.op;
            r_a  <= bus.A;
            r_b  <= bus.B;
        end
    end

    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = r_done;
    assign bus.HI        = r_hi;
    assign bus.LO        = r_lo;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit (WIDTH=32, MUL_LAT=5,
// DIV_LAT=10) checked against a plain-arithmetic HI/LO reference model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W    = 32;
    localparam int MLAT = 5;
    localparam int DLAT = 10;

    logic clk;
    logic reset;

    int n_checks;
    int n_errors;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        logic         done;
    } vec_t;

    muldiv_unit_if #(.WIDTH(W)) bus_if ();

    muldiv_unit #(
        .WIDTH   (W),
        .MUL_LAT (MLAT),
        .DIV_LAT (DLAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // reference model: HI/LO after an op, straight from the arithmetic rules
    task automatic model_apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa;
        longint       sb;
        longint       q;
        longint       r;
        logic [63:0]  p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_DIV: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            OP_DIVU: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int model_lat(input logic [2:0] op);
        if (op == OP_MULT || op == OP_MULTU) return MLAT;
        if (op == OP_DIV || op == OP_DIVU) return DLAT;
        return 0;
    endfunction

    // driver: issue one request, scramble inputs while busy, report outcome
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int busy_cyc, output logic done_end, output logic done_late,
                         output logic [W-1:0] hi, output logic [W-1:0] lo);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.A     = a;
        bus_if.B     = b;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.op    = 3'($urandom_range(0, 7));
        bus_if.A     = $urandom;
        bus_if.B     = $urandom;
        busy_cyc = 0;
        while (bus_if.busy === 1'b1 && busy_cyc < 100) begin
            busy_cyc++;
            @(negedge clk);
            bus_if.A = $urandom;
            bus_if.B = $urandom;
        end
        done_end = bus_if.done;
        hi       = bus_if.HI;
        lo       = bus_if.LO;
        @(negedge clk);
        done_late = bus_if.done;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.op    = OP_NONE;
        bus_if.A     = '0;
        bus_if.B     = '0;
        m_hi = '0;
        m_lo = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus_if.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_busy: got %b expected 0", bus_if.busy);
        end
        n_checks++;
        if (bus_if.done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_done: got %b expected 0", bus_if.done);
        end
        n_checks++;
        if (bus_if.HI !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_hi: got %h expected 00000000", bus_if.HI);
        end
        n_checks++;
        if (bus_if.LO !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_lo: got %h expected 00000000", bus_if.LO);
        end
        reset = 1'b1;
    endtask

    task automatic test_directed();
        vec_t         v [9];
        int           bc;
        logic         de;
        logic         dl;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        v[0] = '{OP_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, MLAT, 1'b1};
        v[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, MLAT, 1'b1};
        v[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, DLAT, 1'b1};
        v[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DLAT, 1'b1};
        v[4] = '{OP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h80000000, 0,    1'b0};
        v[5] = '{OP_MTLO,  32'h00000007, 32'h0,        32'h12345678, 32'h00000007, 0,    1'b0};
        v[6] = '{OP_DIVU,  32'h00000007, 32'h0,        32'h12345678, 32'h00000007, DLAT, 1'b1};
        v[7] = '{OP_NONE,  32'h00005555, 32'h1,        32'h12345678, 32'h00000007, 0,    1'b0};
        v[8] = '{3'd7,     32'h00003333, 32'h1,        32'h12345678, 32'h00000007, 0,    1'b0};
        for (int i = 0; i < 9; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, bc, de, dl, hi, lo);
            model_apply(v[i].op, v[i].a, v[i].b);
            n_checks++;
            if (bc !== v[i].lat) begin
                n_errors++;
                $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, v[i].lat);
            end
            n_checks++;
            if (de !== v[i].done) begin
                n_errors++;
                $display("FAIL dir%0d_done: got %b expected %b", i, de, v[i].done);
            end
            n_checks++;
            if (dl !== 1'b0) begin
                n_errors++;
                $display("FAIL dir%0d_done_width: got %b expected 0", i, dl);
            end
            n_checks++;
            if (hi !== v[i].hi) begin
                n_errors++;
                $display("FAIL dir%0d_hi: got %h expected %h", i, hi, v[i].hi);
            end
            n_checks++;
            if (lo !== v[i].lo) begin
                n_errors++;
                $display("FAIL dir%0d_lo: got %h expected %h", i, lo, v[i].lo);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           bc;
        int           sel;
        logic         de;
        logic         dl;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            if (sel == 1) b = 32'hFFFFFFFF;
            if (sel == 2) a = 32'h80000000;
            if (sel == 3) b = 32'($urandom_range(1, 9));
            do_op(op, a, b, bc, de, dl, hi, lo);
            model_apply(op, a, b);
            n_checks++;
            if (bc !== model_lat(op)) begin
                n_errors++;
                $display("FAIL rnd%0d_busy_cycles op=%0d: got %0d expected %0d", i, op, bc, model_lat(op));
            end
            n_checks++;
            if (de !== (model_lat(op) != 0)) begin
                n_errors++;
                $display("FAIL rnd%0d_done op=%0d: got %b expected %b", i, op, de, model_lat(op) != 0);
            end
            n_checks++;
            if (dl !== 1'b0) begin
                n_errors++;
                $display("FAIL rnd%0d_done_width: got %b expected 0", i, dl);
            end
            n_checks++;
            if (hi !== m_hi) begin
                n_errors++;
                $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, hi, m_hi);
            end
            n_checks++;
            if (lo !== m_lo) begin
                n_errors++;
                $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, lo, m_lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        int           bc;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = OP_MULT;
        bus_if.A     = a1;
        bus_if.B     = b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        bc = 0;
        while (bus_if.busy === 1'b1 && bc < 100) begin
            bc++;
            if (bc == 2) begin
                bus_if.start = 1'b1;
                bus_if.op    = OP_MTLO;
                bus_if.A     = 32'h0000AAAA;
            end else if (bc == 3) begin
                bus_if.start = 1'b1;
                bus_if.op    = OP_DIV;
                bus_if.A     = 32'd100;
                bus_if.B     = 32'd3;
            end else begin
                bus_if.start = 1'b0;
            end
            @(negedge clk);
        end
        model_apply(OP_MULT, a1, b1);
        n_checks++;
        if (bc !== MLAT) begin
            n_errors++;
            $display("FAIL b2b_first_busy_cycles: got %0d expected %0d", bc, MLAT);
        end
        n_checks++;
        if (bus_if.done !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_first_done: got %b expected 1", bus_if.done);
        end
        n_checks++;
        if (bus_if.HI !== m_hi || bus_if.LO !== m_lo) begin
            n_errors++;
            $display("FAIL b2b_first_result: got %h_%h expected %h_%h", bus_if.HI, bus_if.LO, m_hi, m_lo);
        end
        // issue the next multiply during the done cycle
        bus_if.start = 1'b1;
        bus_if.op    = OP_MULTU;
        bus_if.A     = a2;
        bus_if.B     = b2;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.A     = $urandom;
        n_checks++;
        if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_accept_on_done: got busy=%b done=%b expected busy=1 done=0", bus_if.busy, bus_if.done);
        end
        bc = 0;
        while (bus_if.busy === 1'b1 && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        model_apply(OP_MULTU, a2, b2);
        n_checks++;
        if (bc !== MLAT) begin
            n_errors++;
            $display("FAIL b2b_second_busy_cycles: got %0d expected %0d", bc, MLAT);
        end
        n_checks++;
        if (bus_if.done !== 1'b1 || bus_if.HI !== m_hi || bus_if.LO !== m_lo) begin
            n_errors++;
            $display("FAIL b2b_second_result: got done=%b %h_%h expected done=1 %h_%h",
                     bus_if.done, bus_if.HI, bus_if.LO, m_hi, m_lo);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int           bc;
        logic         de;
        logic         dl;
        logic         seen_busy;
        logic         seen_done;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        do_op(OP_MTHI, 32'hCAFEF00D, 32'h0, bc, de, dl, hi, lo);
        model_apply(OP_MTHI, 32'hCAFEF00D, 32'h0);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = OP_DIV;
        bus_if.A     = 32'd1000;
        bus_if.B     = 32'd7;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (2) @(negedge clk);
        // now in busy cycle 3; pull reset between edges
        #2;
        reset = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        n_checks++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_flags: got busy=%b done=%b expected 0 0", bus_if.busy, bus_if.done);
        end
        n_checks++;
        if (bus_if.HI !== 32'h0 || bus_if.LO !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset_hilo: got %h_%h expected 00000000_00000000", bus_if.HI, bus_if.LO);
        end
        @(negedge clk);
        // release and immediately request: accepted on the first edge
        reset        = 1'b1;
        bus_if.start = 1'b1;
        bus_if.op    = OP_MTLO;
        bus_if.A     = 32'h00005A5A;
        @(negedge clk);
        bus_if.start = 1'b0;
        model_apply(OP_MTLO, 32'h00005A5A, 32'h0);
        n_checks++;
        if (bus_if.LO !== m_lo || bus_if.HI !== m_hi) begin
            n_errors++;
            $display("FAIL first_start_after_reset: got %h_%h expected %h_%h", bus_if.HI, bus_if.LO, m_hi, m_lo);
        end
        seen_busy = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < DLAT + 3; i++) begin
            seen_busy |= bus_if.busy;
            seen_done |= bus_if.done;
            @(negedge clk);
        end
        n_checks++;
        if (seen_busy !== 1'b0 || seen_done !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_no_done: got busy_seen=%b done_seen=%b expected 0 0", seen_busy, seen_done);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, 32, operand and HI/LO width in bits (>=8).
REQ-002 Parameter MUL_LAT, 5, busy cycles for MULT/MULTU (>=1).
REQ-003 Parameter DIV_LAT, 10, busy cycles for DIV/DIVU (>=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request strobe, sampled on the rising edge.
REQ-007 op  input  3  operation code per shared package: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-008 A  input  WIDTH  operand rs (dividend / multiplicand / MTHI-MTLO data).
REQ-009 B  input  WIDTH  operand rt (divisor / multiplier).
REQ-010 busy  output  1  high while an arithmetic op is in flight.
REQ-011 done  output  1  one-cycle pulse when HI/LO take an arithmetic result.
REQ-012 HI  output  WIDTH  HI register, registered output (MFHI source).
REQ-013 LO  output  WIDTH  LO register, registered output (MFLO source).

Function
REQ-014 FSM SHALL have two states: IDLE and RUN.
REQ-015 In IDLE, start=1 with op in {MULT,MULTU,DIV,DIVU} SHALL latch A, B and op and enter RUN, loading a down-counter with MUL_LAT or DIV_LAT.
REQ-016 busy SHALL be high for exactly the latency in cycles, starting the cycle after the accepting edge.
REQ-017 On the edge ending the last busy cycle, HI/LO SHALL update, FSM SHALL return to IDLE, busy SHALL fall and done SHALL be high for the following cycle only.
REQ-018 MULT/MULTU SHALL form the 2*WIDTH-bit signed/unsigned product; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-019 DIV/DIVU SHALL put the quotient in LO and the remainder in HI; signed division truncates toward zero and the remainder takes the dividend's sign.
REQ-020 Signed DIV of most-negative value by -1 SHALL give LO = most-negative value, HI = 0.
REQ-021 Division by zero SHALL leave HI/LO unchanged, still occupy DIV_LAT busy cycles and still pulse done.
REQ-022 In IDLE, start=1 with MTHI (MTLO) SHALL write A into HI (LO) on that edge; busy and done SHALL stay low.
REQ-023 Any start while busy=1 (any op) SHALL be ignored; no state change.
REQ-024 start=1 with op=NONE or an undefined code SHALL be ignored.
REQ-025 In the done cycle the unit is IDLE and SHALL accept a new start on that edge.
REQ-026 Latched operands SHALL be used; changes to A/B during RUN SHALL NOT affect the result.

Reset
REQ-027 reset=0 SHALL asynchronously force HI=0, LO=0, busy=0, done=0, counter=0, state=IDLE, including mid-operation; the in-flight result SHALL be discarded.
REQ-028 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 Op-code constants and the FSM state encoding SHALL live in the shared definitions package used by the processor.
REQ-030 Single module; no sub-module. Results SHALL be computed combinationally from latched operands and committed at the final edge.

Verification (MUL_LAT=5, DIV_LAT=10, WIDTH=32)
REQ-031 MULT A=0xFFFFFFFF, B=2 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE, done pulses once.
REQ-032 MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 DIV A=0xFFFFFFF9, B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 MTHI 0x12345678, MTLO 7, then DIVU A=7, B=0 -> busy 10 cycles, done pulses, HI=0x12345678, LO=7 unchanged.
REQ-035 MULT accepted, then MTLO 0xAAAA and DIV issued during busy -> both ignored; back-to-back MULT on the done edge is accepted.
REQ-036 Assert reset at busy cycle 3 of DIV -> HI=LO=0, busy=0 immediately; no done pulse afterwards.
